// File: rtl/gray_disp_pkg.sv
// ---------------------------------------------------------------------------
// gray_disp_pkg
// Shared types and helpers for the Gray-code switch display controller:
//   dbnc_state_t  - debounce FSM state encoding
//   SEG_*         - active-low 7-segment codes (bit 0 = a ... bit 6 = g)
//   AN_*          - active-low digit enables (bit 0 = units, bit 1 = tens)
//   seg_decode()  - decimal digit 0-9 to active-low segment pattern
// ---------------------------------------------------------------------------
package gray_disp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      COMMIT = 2'd2
   } dbnc_state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_ONE   = 7'b1111001;

   localparam logic [1:0] AN_UNITS  = 2'b10;
   localparam logic [1:0] AN_TENS   = 2'b01;

   // Digits above 9 never reach the decoder; blank them defensively.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] v_seg;
      case (digit)
         4'd0:    v_seg = 7'b1000000;
         4'd1:    v_seg = 7'b1111001;
         4'd2:    v_seg = 7'b0100100;
         4'd3:    v_seg = 7'b0110000;
         4'd4:    v_seg = 7'b0011001;
         4'd5:    v_seg = 7'b0010010;
         4'd6:    v_seg = 7'b0000010;
         4'd7:    v_seg = 7'b1111000;
         4'd8:    v_seg = 7'b0000000;
         4'd9:    v_seg = 7'b0010000;
         default: v_seg = SEG_BLANK;
      endcase
      return v_seg;
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// ---------------------------------------------------------------------------
// sync_debounce
// Two-flop synchroniser followed by an IDLE/CHECK/COMMIT debounce FSM.
// A new Gray value is accepted only after it has been seen unchanged on the
// synchronised input for DEBOUNCE_CYCLES consecutive CHECK cycles.
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   raw     in   [3:0] asynchronous Gray-coded switch input
//   stable  out  [3:0] last committed Gray value (registered)
//   commit  out  one-cycle pulse while the FSM sits in COMMIT
// ---------------------------------------------------------------------------
module sync_debounce
   import gray_disp_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] raw,
   output logic [3:0] stable,
   output logic       commit
);

   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [3:0]       r_cand;
   logic [3:0]       r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_commit;
   dbnc_state_t      r_state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_cand   <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
         r_commit <= 1'b0;
         r_state  <= IDLE;
      end else begin
         r_sync1  <= raw;
         r_sync2  <= r_sync1;
         r_commit <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_sync2 != r_stable) begin
                  r_cand  <= r_sync2;
                  r_cnt   <= '0;
                  r_state <= CHECK;
               end
            end
            CHECK: begin
               // Any change (including a return to the old stable value)
               // abandons this candidate without committing it.
               if (r_sync2 != r_cand) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  // stable and the pulse are loaded on entry to COMMIT so
                  // the new value is visible for the whole COMMIT cycle.
                  r_stable <= r_cand;
                  r_commit <= 1'b1;
                  r_state  <= COMMIT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            COMMIT: begin
               r_cnt   <= '0;
               r_state <= IDLE;
            end
            default: begin
               r_cnt   <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign stable = r_stable;
   assign commit = r_commit;

endmodule

// File: rtl/gray_display_ctrl.sv
// ---------------------------------------------------------------------------
// gray_display_ctrl
// Debounces a 4-bit Gray-coded switch bank, converts the committed value to
// binary for the LEDs and shows it as decimal 0-15 on a 2-digit
// time-multiplexed active-low 7-segment display.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   gray_in  in   [3:0] raw Gray-coded switch input (asynchronous)
//   led      out  [3:0] committed binary value, led[3] = MSB
//   seg      out  [6:0] active-low segments, seg[0] = a ... seg[6] = g
//   an       out  [1:0] active-low digit enables, an[0] = units, an[1] = tens
//   valid    out  one-cycle pulse when a new value is committed
// ---------------------------------------------------------------------------
module gray_display_ctrl
   import gray_disp_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int REFRESH_CYCLES  = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] gray_in,
   output logic [3:0] led,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       valid
);

   localparam int               REF_W    = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

   logic [3:0]       w_stable;
   logic             w_commit;
   logic [3:0]       w_bin;
   logic [3:0]       w_units;
   logic             w_has_tens;
   logic             w_ref_wrap;
   logic             w_sel_next;
   logic [6:0]       w_seg_units;
   logic [6:0]       w_seg_tens;

   logic [REF_W-1:0] r_ref_cnt;
   logic             r_digit_sel;   // 0 = units, 1 = tens
   logic [6:0]       r_seg;
   logic [1:0]       r_an;

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sync_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (gray_in),
      .stable (w_stable),
      .commit (w_commit)
   );

   // Binary bit i is the XOR of all Gray bits at or above i.
   for (genvar gi = 0; gi < 4; gi++) begin : g_gray2bin
      assign w_bin[gi] = ^w_stable[3:gi];
   end

   assign w_has_tens  = (w_bin >= 4'd10);
   assign w_units     = w_has_tens ? (w_bin - 4'd10) : w_bin;
   assign w_seg_units = seg_decode(w_units);
   assign w_seg_tens  = w_has_tens ? SEG_ONE : SEG_BLANK;

   assign w_ref_wrap  = (r_ref_cnt == REF_LAST);
   assign w_sel_next  = r_digit_sel ^ w_ref_wrap;

   // seg and an are loaded from the same next-digit select so the segment
   // pattern always belongs to the digit being enabled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ref_cnt   <= '0;
         r_digit_sel <= 1'b0;
         r_an        <= AN_UNITS;
         r_seg       <= SEG_ZERO;
      end else begin
         r_ref_cnt   <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
         r_digit_sel <= w_sel_next;
         r_an        <= w_sel_next ? AN_TENS : AN_UNITS;
         r_seg       <= w_sel_next ? w_seg_tens : w_seg_units;
      end
   end

   assign led   = w_bin;
   assign seg   = r_seg;
   assign an    = r_an;
   assign valid = w_commit;

endmodule
